// File: rtl/conv_postproc_pool_stream.sv
// rtl/conv_postproc_pool_stream.sv - conv post-processing (bias, ReLU, requantise) with 2x2 max-pool stream
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   s_valid/s_ready   input pixel handshake (s_ready = !m_valid || m_ready)
//   s_data            NUM_OUTPUTS x IN_WIDTH signed conv results, channel i at [i*IN_WIDTH +: IN_WIDTH]
//   bias              NUM_OUTPUTS x IN_WIDTH signed per-channel bias (quasi-static)
//   shift             requantise arithmetic right shift (quasi-static)
//   m_valid/m_ready   pooled pixel handshake
//   m_data            NUM_OUTPUTS x OUT_WIDTH signed pooled pixel, channel i at [i*OUT_WIDTH +: OUT_WIDTH]
//   m_last            final pooled pixel of a frame
module conv_postproc_pool_stream #(
    parameter int IN_WIDTH    = 24,
    parameter int OUT_WIDTH   = 8,
    parameter int NUM_OUTPUTS = 4,
    parameter int IMG_WIDTH   = 4,
    parameter int IMG_HEIGHT  = 4,
    parameter int RELU_EN     = 1,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [NUM_OUTPUTS*IN_WIDTH-1:0]  s_data,
    input  logic [NUM_OUTPUTS*IN_WIDTH-1:0]  bias,
    input  logic [SHIFT_WIDTH-1:0]           shift,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [NUM_OUTPUTS*OUT_WIDTH-1:0] m_data,
    output logic                             m_last
);

    localparam int SW  = IN_WIDTH + 1;
    localparam int CW  = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW  = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
    localparam int HW  = IMG_WIDTH / 2;
    localparam int LBW = (HW > 1) ? $clog2(HW) : 1;

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

    localparam logic signed [SW-1:0] QMAX = SW'((1 <<< (OUT_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] QMIN = -QMAX - SW'(1);

    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [LBW-1:0] lb_idx;
    logic           accept;
    logic           load;
    logic           shift_big;

    logic signed [OUT_WIDTH-1:0] pair_q  [NUM_OUTPUTS];
    logic signed [OUT_WIDTH-1:0] linebuf [HW][NUM_OUTPUTS];

    logic signed [OUT_WIDTH-1:0] q_w    [NUM_OUTPUTS];
    logic signed [OUT_WIDTH-1:0] hmax_w [NUM_OUTPUTS];
    logic signed [OUT_WIDTH-1:0] pool_w [NUM_OUTPUTS];

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;
    // The fourth pixel of each 2x2 window lands on odd row, odd col.
    assign load    = accept && row[0] && col[0];
    assign lb_idx  = LBW'(col >> 1);

    // Shifts at or beyond the sum width collapse to pure sign fill.
    assign shift_big = ({{(32 - SHIFT_WIDTH){1'b0}}, shift} >= 32'(SW));

    // Bias add, optional ReLU, requantise shift and saturation per channel.
    always_comb begin
        logic [IN_WIDTH-1:0]   d_v;
        logic [IN_WIDTH-1:0]   b_v;
        logic signed [SW-1:0]  sum_v;
        logic signed [SW-1:0]  relu_v;
        logic signed [SW-1:0]  shr_v;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            d_v   = s_data[i*IN_WIDTH +: IN_WIDTH];
            b_v   = bias[i*IN_WIDTH +: IN_WIDTH];
            sum_v = $signed({d_v[IN_WIDTH-1], d_v}) + $signed({b_v[IN_WIDTH-1], b_v});
            if ((RELU_EN != 0) && sum_v[SW-1]) begin
                relu_v = '0;
            end else begin
                relu_v = sum_v;
            end
            if (shift_big) begin
                shr_v = {SW{relu_v[SW-1]}};
            end else begin
                shr_v = relu_v >>> shift;
            end
            if (shr_v > QMAX) begin
                q_w[i] = QMAX[OUT_WIDTH-1:0];
            end else if (shr_v < QMIN) begin
                q_w[i] = QMIN[OUT_WIDTH-1:0];
            end else begin
                q_w[i] = shr_v[OUT_WIDTH-1:0];
            end
        end
    end

    // Horizontal max against the even-column pair register, then vertical
    // max against the entry stored while on the even row above.
    always_comb begin
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            hmax_w[i] = (pair_q[i] > q_w[i]) ? pair_q[i] : q_w[i];
            pool_w[i] = (linebuf[lb_idx][i] > hmax_w[i]) ? linebuf[lb_idx][i] : hmax_w[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                pair_q[i] <= '0;
                for (int j = 0; j < HW; j++) begin
                    linebuf[j][i] <= '0;
                end
            end
        end else begin
            // A handshake empties the output stage; a load below overrides it.
            if (m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end

            if (accept) begin
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end

                for (int i = 0; i < NUM_OUTPUTS; i++) begin
                    if (!col[0]) begin
                        pair_q[i] <= q_w[i];
                    end else if (!row[0]) begin
                        linebuf[lb_idx][i] <= hmax_w[i];
                    end
                end
            end

            if (load) begin
                m_valid <= 1'b1;
                m_last  <= (row == ROW_MAX) && (col == COL_MAX);
                for (int i = 0; i < NUM_OUTPUTS; i++) begin
                    m_data[i*OUT_WIDTH +: OUT_WIDTH] <= pool_w[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_postproc_pool_stream.sv
// tb/tb_conv_postproc_pool_stream.sv - directed bench for conv_postproc_pool_stream (ReLU on and off)
module tb_conv_postproc_pool_stream;

    localparam int IW = 24;
    localparam int OW = 8;
    localparam int NO = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b1;
    logic [NO*IW-1:0] s_data = '0;
    logic [NO*IW-1:0] bias = '0;
    logic [4:0]    shift = '0;

    logic             r_s_ready, n_s_ready;
    logic             r_m_valid, n_m_valid;
    logic             r_m_last, n_m_last;
    logic [NO*OW-1:0] r_m_data, n_m_data;

    int checks = 0;
    int errors = 0;

    int q_r0[$], q_r1[$], q_n0[$], q_n1[$], q_last[$], q_nsync[$];

    always #5 clk = ~clk;

    conv_postproc_pool_stream #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM_OUTPUTS(NO),
        .IMG_WIDTH(4), .IMG_HEIGHT(4), .RELU_EN(1), .SHIFT_WIDTH(5)
    ) dut_r (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(r_s_ready),
        .s_data(s_data), .bias(bias), .shift(shift),
        .m_valid(r_m_valid), .m_ready(m_ready), .m_data(r_m_data), .m_last(r_m_last)
    );

    conv_postproc_pool_stream #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM_OUTPUTS(NO),
        .IMG_WIDTH(4), .IMG_HEIGHT(4), .RELU_EN(0), .SHIFT_WIDTH(5)
    ) dut_n (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(n_s_ready),
        .s_data(s_data), .bias(bias), .shift(shift),
        .m_valid(n_m_valid), .m_ready(m_ready), .m_data(n_m_data), .m_last(n_m_last)
    );

    // Record every output handshake that the coming rising edge will complete.
    always @(negedge clk) begin
        if (!rst && r_m_valid && m_ready) begin
            q_r0.push_back(int'($signed(r_m_data[7:0])));
            q_r1.push_back(int'($signed(r_m_data[15:8])));
            q_n0.push_back(int'($signed(n_m_data[7:0])));
            q_n1.push_back(int'($signed(n_m_data[15:8])));
            q_last.push_back(int'(r_m_last));
            q_nsync.push_back(int'(n_m_valid && (n_m_last == r_m_last)));
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int b0, input int b1, input int sh);
        logic [31:0] t0, t1;
        t0 = b0;
        t1 = b1;
        bias[0 +: IW]  = t0[IW-1:0];
        bias[IW +: IW] = t1[IW-1:0];
        shift = sh[4:0];
    endtask

    task automatic send_pixel(input int d0, input int d1);
        logic [31:0] t0, t1;
        int ok;
        t0 = d0;
        t1 = d1;
        s_data[0 +: IW]  = t0[IW-1:0];
        s_data[IW +: IW] = t1[IW-1:0];
        s_valid = 1'b1;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (r_s_ready) begin
                ok = 1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (ok == 0) chk("accept_timeout", ok, 1);
    endtask

    task automatic send_frame(input int b0, input int st0, input int b1, input int st1, input bit gaps);
        for (int p = 0; p < 16; p++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_pixel(b0 + st0 * p, b1 + st1 * p);
        end
    endtask

    task automatic drain();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        q_r0.delete(); q_r1.delete(); q_n0.delete();
        q_n1.delete(); q_last.delete(); q_nsync.delete();
    endtask

    task automatic check_frame(input string tag, input int n,
                               input int er0[8], input int er1[8],
                               input int en0[8], input int en1[8]);
        chk({tag, "_count"}, q_r0.size(), n);
        for (int i = 0; i < n && i < q_r0.size(); i++) begin
            chk($sformatf("%s_relu_ch0[%0d]", tag, i), q_r0[i], er0[i]);
            chk($sformatf("%s_relu_ch1[%0d]", tag, i), q_r1[i], er1[i]);
            chk($sformatf("%s_norelu_ch0[%0d]", tag, i), q_n0[i], en0[i]);
            chk($sformatf("%s_norelu_ch1[%0d]", tag, i), q_n1[i], en1[i]);
            chk($sformatf("%s_last[%0d]", tag, i), q_last[i], int'((i % 4) == 3));
            chk($sformatf("%s_norelu_sync[%0d]", tag, i), q_nsync[i], 1);
        end
        clear_q();
    endtask

    initial begin
        // Reset state
        set_cfg(0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", int'(r_m_valid), 0);
        chk("rst_m_last", int'(r_m_last), 0);
        chk("rst_m_data", int'(r_m_data), 0);
        chk("rst_s_ready", int'(r_s_ready), 1);
        chk("rst_norelu_m_valid", int'(n_m_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Ramp 0..15 on ch0, negative ramp on ch1, full-rate input
        send_frame(0, 1, 0, -1, 1'b0);
        drain();
        check_frame("ramp", 4, '{5, 7, 13, 15, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
                    '{5, 7, 13, 15, 0, 0, 0, 0}, '{0, -2, -8, -10, 0, 0, 0, 0});

        // Saturation both ways
        set_cfg(0, 0, 2);
        send_frame(1000, 0, -1000, 0, 1'b0);
        drain();
        check_frame("sat", 4, '{127, 127, 127, 127, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
                    '{127, 127, 127, 127, 0, 0, 0, 0}, '{-128, -128, -128, -128, 0, 0, 0, 0});

        // Bias makes a negative sum: ReLU clamps, bypass keeps -40
        set_cfg(10, 0, 0);
        send_frame(-50, 0, 5, 0, 1'b0);
        drain();
        check_frame("relu", 4, '{0, 0, 0, 0, 0, 0, 0, 0}, '{5, 5, 5, 5, 0, 0, 0, 0},
                    '{-40, -40, -40, -40, 0, 0, 0, 0}, '{5, 5, 5, 5, 0, 0, 0, 0});

        // Shift by 3 with negative bias
        set_cfg(-20, 0, 3);
        send_frame(100, 0, -1000, 0, 1'b0);
        drain();
        check_frame("shift3", 4, '{10, 10, 10, 10, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
                    '{10, 10, 10, 10, 0, 0, 0, 0}, '{-125, -125, -125, -125, 0, 0, 0, 0});

        // Shift beyond the sum width: sign fill
        set_cfg(0, 0, 31);
        send_frame(5, 0, -5, 0, 1'b0);
        drain();
        check_frame("shift31", 4, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
                    '{0, 0, 0, 0, 0, 0, 0, 0}, '{-1, -1, -1, -1, 0, 0, 0, 0});

        // Backpressure: first output held 3 cycles with input stalled
        set_cfg(0, 0, 0);
        m_ready = 1'b0;
        for (int p = 0; p < 6; p++) send_pixel(p, -p);
        s_data[0 +: IW] = 24'd6;
        s_data[IW +: IW] = -24'sd6;
        s_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp_m_valid[%0d]", c), int'(r_m_valid), 1);
            chk($sformatf("bp_m_data[%0d]", c), int'($signed(r_m_data[7:0])), 5);
            chk($sformatf("bp_s_ready[%0d]", c), int'(r_s_ready), 0);
            chk($sformatf("bp_norelu_s_ready[%0d]", c), int'(n_s_ready), 0);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        for (int p = 6; p < 16; p++) send_pixel(p, -p);
        drain();
        check_frame("bp", 4, '{5, 7, 13, 15, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
                    '{5, 7, 13, 15, 0, 0, 0, 0}, '{0, -2, -8, -10, 0, 0, 0, 0});

        // Reset mid-frame after 6 accepted pixels
        for (int p = 0; p < 6; p++) send_pixel(100, 100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_m_valid", int'(r_m_valid), 0);
        chk("midrst_m_data", int'(r_m_data), 0);
        chk("midrst_m_last", int'(r_m_last), 0);
        clear_q();
        send_frame(0, 1, 0, -1, 1'b0);
        drain();
        check_frame("midrst", 4, '{5, 7, 13, 15, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
                    '{5, 7, 13, 15, 0, 0, 0, 0}, '{0, -2, -8, -10, 0, 0, 0, 0});

        // Two back-to-back frames with random input gaps
        send_frame(0, 1, 0, -1, 1'b1);
        send_frame(16, 1, -16, -1, 1'b1);
        drain();
        check_frame("two", 8, '{5, 7, 13, 15, 21, 23, 29, 31}, '{0, 0, 0, 0, 0, 0, 0, 0},
                    '{5, 7, 13, 15, 21, 23, 29, 31}, '{0, -2, -8, -10, -16, -18, -24, -26});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
